// File: rtl/r200_wb.sv
// r200 writeback stage: captures execute results, runs the data-memory
// handshake for loads/stores and drives the register-file write port.
module r200_wb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pcp4,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_regwr,
    input  logic        in_memwr,
    input  logic [1:0]  in_wbsel,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        regwr_out,
    output logic [4:0]  rdaddr_out,
    output logic [31:0] reg_win
);

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        WB
    } state_t;

    state_t      state;
    logic [31:0] cap_alu;
    logic [31:0] cap_pcp4;
    logic [31:0] cap_rs2;
    logic [31:0] ld_data;
    logic [4:0]  cap_rd;
    logic        cap_regwr;
    logic        cap_memwr;
    logic [1:0]  cap_wbsel;
    logic        xfer;
    logic        is_mem;

    assign in_ready = (state != MEM);
    assign xfer     = in_valid & in_ready;
    assign is_mem   = in_memwr | (in_wbsel == 2'b01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_alu   <= '0;
            cap_pcp4  <= '0;
            cap_rs2   <= '0;
            ld_data   <= '0;
            cap_rd    <= '0;
            cap_regwr <= 1'b0;
            cap_memwr <= 1'b0;
            cap_wbsel <= 2'b00;
        end else begin
            // capture only outside MEM, so the request fields stay stable
            if (xfer) begin
                cap_alu   <= in_alu;
                cap_pcp4  <= in_pcp4;
                cap_rs2   <= in_rs2;
                cap_rd    <= in_rd;
                cap_regwr <= in_regwr;
                cap_memwr <= in_memwr;
                cap_wbsel <= in_wbsel;
            end
            unique case (state)
                IDLE, WB: begin
                    if (xfer) state <= is_mem ? MEM : WB;
                    else      state <= IDLE;
                end
                MEM: begin
                    if (dm_ack) begin
                        ld_data <= dm_rdata;
                        state   <= WB;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dm_req     = (state == MEM);
    assign dm_we      = dm_req & cap_memwr;
    assign dm_addr    = cap_alu;
    assign dm_wdata   = cap_rs2;
    assign regwr_out  = (state == WB) & cap_regwr & ~cap_memwr
                        & (cap_rd != 5'd0);
    assign rdaddr_out = cap_rd;

    always_comb begin
        reg_win = cap_alu;
        unique case (1'b1)
            (cap_wbsel == 2'b01): reg_win = ld_data;
            (cap_wbsel == 2'b10): reg_win = cap_pcp4;
            default:              reg_win = cap_alu;
        endcase
    end

endmodule

// File: tb/tb_r200_wb.sv
// Scoreboard bench for r200_wb: directed vectors push expected writebacks,
// a monitor pops and compares them in the cycle they are due.
module tb_r200_wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_alu = '0;
    logic [31:0] in_pcp4 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic        in_regwr = 1'b0;
    logic        in_memwr = 1'b0;
    logic [1:0]  in_wbsel = '0;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        regwr_out;
    logic [4:0]  rdaddr_out;
    logic [31:0] reg_win;

    typedef struct {
        int          cyc;
        logic        regwr;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    r200_wb dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu(in_alu), .in_pcp4(in_pcp4), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_regwr(in_regwr), .in_memwr(in_memwr),
        .in_wbsel(in_wbsel),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .regwr_out(regwr_out), .rdaddr_out(rdaddr_out), .reg_win(reg_win)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // monitor: compares writeback port against due scoreboard entries
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL wb_missing: rd %0d due cyc %0d now %0d",
                         e.rd, e.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("wb_regwr", {31'd0, regwr_out}, {31'd0, e.regwr});
                chk("wb_rd", {27'd0, rdaddr_out}, {27'd0, e.rd});
                chk("wb_data", reg_win, e.data);
            end else begin
                chk("wb_spurious", {31'd0, regwr_out}, 32'd0);
            end
        end
    end

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] pcp4, input logic [1:0] sel,
                          input logic regwr);
        chk("alu_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_rd    = rd;
        in_alu   = alu;
        in_pcp4  = pcp4;
        in_rs2   = 32'h5555_AAAA;
        in_wbsel = sel;
        in_regwr = regwr;
        in_memwr = 1'b0;
        q.push_back('{cyc + 1, regwr && rd != 5'd0, rd,
                     (sel == 2'b10) ? pcp4 : alu});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic mem_op(input logic st, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [4:0] rd,
                          input logic [31:0] rdata, input int k);
        chk("mem_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_alu   = addr;
        in_pcp4  = addr + 32'd4;
        in_rs2   = rs2;
        in_rd    = rd;
        in_regwr = 1'b1;
        in_memwr = st;
        in_wbsel = st ? 2'b00 : 2'b01;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            chk("dm_req", {31'd0, dm_req}, 32'd1);
            chk("dm_we", {31'd0, dm_we}, {31'd0, st});
            chk("dm_addr", dm_addr, addr);
            chk("dm_wdata", dm_wdata, rs2);
            chk("mem_busy", {31'd0, in_ready}, 32'd0);
            if (i == k - 1) begin
                dm_ack   = 1'b1;
                dm_rdata = rdata;
                q.push_back('{cyc + 1, !st && rd != 5'd0, rd,
                             st ? addr : rdata});
            end
            @(negedge clk);
        end
        dm_ack   = 1'b0;
        dm_rdata = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        chk("rst_we", {31'd0, dm_we}, 32'd0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_wdata", dm_wdata, 32'd0);
        chk("rst_regwr", {31'd0, regwr_out}, 32'd0);
        chk("rst_rd", {27'd0, rdaddr_out}, 32'd0);
        chk("rst_win", reg_win, 32'd0);
        rst_n = 1'b1;
        chk("rel_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        alu_op(5'd5, 32'h1234_5678, 32'h0000_1004, 2'b00, 1'b1);
        idle(1);
        chk("idle_req", {31'd0, dm_req}, 32'd0);

        mem_op(1'b0, 32'h100, 32'h0, 5'd7, 32'hDEAD_BEEF, 3);
        idle(1);
        mem_op(1'b1, 32'h200, 32'hCAFE_F00D, 5'd8, 32'h0BAD_0BAD, 1);
        idle(1);

        alu_op(5'd0, 32'h0000_0011, 32'h0, 2'b00, 1'b1);
        alu_op(5'd3, 32'h0000_0033, 32'h0, 2'b00, 1'b1);
        alu_op(5'd9, 32'h0000_0099, 32'h44, 2'b10, 1'b1);
        alu_op(5'd4, 32'hA5A5_0000, 32'h88, 2'b11, 1'b1);
        alu_op(5'd6, 32'h0000_0066, 32'h0, 2'b00, 1'b0);
        idle(1);

        // accept from WB straight after a load
        mem_op(1'b0, 32'h300, 32'h0, 5'd10, 32'h1357_9BDF, 1);
        mem_op(1'b0, 32'h304, 32'h0, 5'd11, 32'h2468_ACE0, 2);
        alu_op(5'd12, 32'h0000_0C0C, 32'h0, 2'b00, 1'b1);
        idle(1);

        dm_ack   = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dm_ack = 1'b0;
        chk("stray_ack_req", {31'd0, dm_req}, 32'd0);
        idle(1);

        // reset during an outstanding load
        in_valid = 1'b1;
        in_alu   = 32'h400;
        in_rd    = 5'd13;
        in_regwr = 1'b1;
        in_memwr = 1'b0;
        in_wbsel = 2'b01;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rl_req", {31'd0, dm_req}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rl_drop", {31'd0, dm_req}, 32'd0);
        chk("rl_ready", {31'd0, in_ready}, 32'd1);
        chk("rl_addr", dm_addr, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        dm_ack   = 1'b1;
        dm_rdata = 32'h7777_7777;
        @(negedge clk);
        dm_ack = 1'b0;
        chk("rl_after_req", {31'd0, dm_req}, 32'd0);
        chk("rl_after_rdy", {31'd0, in_ready}, 32'd1);
        idle(3);

        chk("sb_drain", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/r200_wb.md
R200_WB -- requirements
Module: r200_wb

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  execute stage presents a result.
REQ-005 in_ready  out  1  block accepts the presented result this cycle.
REQ-006 in_alu  in  32  ALU result; also the data-memory address.
REQ-007 in_pcp4  in  32  PC+4 of the instruction.
REQ-008 in_rs2  in  32  store data.
REQ-009 in_rd  in  5  destination register address.
REQ-010 in_regwr  in  1  instruction writes a register.
REQ-011 in_memwr  in  1  instruction is a store.
REQ-012 in_wbsel  in  2  writeback source: 00 ALU, 01 memory, 10 PC+4, 11 treated as ALU.
REQ-013 dm_req  out  1  data-memory request.
REQ-014 dm_we  out  1  request is a write.
REQ-015 dm_addr  out  32  request address.
REQ-016 dm_wdata  out  32  write data.
REQ-017 dm_ack  in  1  memory completes the request this cycle.
REQ-018 dm_rdata  in  32  load data, valid when dm_ack=1.
REQ-019 regwr_out  out  1  register-file write enable to decode.
REQ-020 rdaddr_out  out  5  register-file write address to decode.
REQ-021 reg_win  out  32  register-file write data to decode.

Function
REQ-022 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; all in_* fields are captured into internal registers on that edge.
REQ-023 The FSM SHALL have exactly three states: IDLE, MEM and WB.
REQ-024 A captured instruction is a memory op when in_memwr=1 or in_wbsel=01.
REQ-025 in_ready SHALL be 1 in IDLE and in WB, and 0 in MEM.
REQ-026 IDLE transitions: transfer of a memory op -> MEM; transfer of any other op -> WB; no transfer -> stay in IDLE.
REQ-027 In MEM: dm_req=1; dm_we=captured memwr; dm_addr=captured alu; dm_wdata=captured rs2.
REQ-028 In MEM, dm_addr, dm_we and dm_wdata SHALL hold stable until the cycle in which dm_ack=1.
REQ-029 MEM with dm_ack=1: dm_rdata SHALL be captured and the FSM SHALL go to WB; MEM with dm_ack=0: stay in MEM, with no timeout.
REQ-030 In WB, regwr_out SHALL equal captured regwr AND NOT captured memwr AND (captured rd != 0), and SHALL be asserted for exactly one cycle per instruction.
REQ-031 In WB: rdaddr_out=captured rd; reg_win = captured alu for wbsel 00/11, load data for 01, captured pcp4 for 10.
REQ-032 WB transitions: a transfer in WB SHALL proceed exactly as from IDLE (to MEM or WB); otherwise WB goes to IDLE.
REQ-033 Throughput: one non-memory instruction per cycle. Writeback occurs in the cycle after the transfer.
REQ-034 Memory op latency: transfer at cycle t; dm_req from t+1; dm_ack at cycle t+k; writeback at t+k+1.
REQ-035 Outside WB, regwr_out SHALL be 0. Outside MEM, dm_req SHALL be 0.
REQ-036 dm_ack received outside MEM SHALL be ignored.
REQ-037 dm_req, dm_we, regwr_out, rdaddr_out and reg_win SHALL be register outputs or decoded only from state registers, with no combinational path from in_* or dm_ack.

Reset
REQ-038 While rst_n=0: state=IDLE; dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, regwr_out=0, rdaddr_out=0, reg_win=0; all captured fields=0.
REQ-039 rst_n=0 during MEM SHALL drop dm_req immediately (asynchronously) and abandon the transaction; a later dm_ack SHALL be ignored.
REQ-040 After rst_n is released, in_ready SHALL be 1 on the first clock edge.

Verification
REQ-041 ALU op, in_alu=0x12345678, rd=5, wbsel=00, regwr=1 -> next cycle: regwr_out=1, rdaddr_out=5, reg_win=0x12345678.
REQ-042 Load, addr=0x100, rd=7, dm_ack three cycles after dm_req, dm_rdata=0xDEADBEEF -> dm_req held 3 cycles with dm_we=0 and dm_addr=0x100; in_ready=0 throughout; next cycle regwr_out=1, rd=7, reg_win=0xDEADBEEF.
REQ-043 Store, addr=0x200, rs2=0xCAFEF00D, ack after one cycle -> dm_we=1, dm_wdata=0xCAFEF00D; the WB cycle has regwr_out=0.
REQ-044 Back-to-back ALU ops to rd=0, rd=3 and a jump with wbsel=10, pcp4=0x44 -> writebacks on consecutive cycles; regwr_out=0 for rd=0; third reg_win=0x44.
REQ-045 Load in progress, rst_n pulsed low before dm_ack, then dm_ack=1 -> dm_req falls during reset; no writeback occurs; state returns to IDLE.
